// File: rtl/seg_accum_array.sv
// seg_accum_array
//   Per-channel segment accumulator. Each channel collects unsigned samples
//   framed by start/end markers and emits the segment sum, with clamp or wrap
//   on overflow. A channel holds one result until its consumer takes it.
//
//   Ports
//     clk, reset   rising-edge clock, synchronous active-high reset
//     in_valid     per-channel sample valid
//     in_start     per-channel segment-open marker
//     in_end       per-channel segment-close marker
//     d            samples, channel c at [c*DATA_W +: DATA_W]
//     in_ready     per-channel accept (free slot, or slot being consumed)
//     q            results, channel c at [c*ACC_W +: ACC_W]
//     q_valid      per-channel result valid
//     q_ready      per-channel result consume
//     q_ovf        per-channel overflow flag, qualified by q_valid
//     err          per-channel sticky protocol error
//
//   state    | meaning
//   ---------+---------------------------------------------
//   ST_IDLE  | no open segment, waiting for a start marker
//   ST_ACCUM | segment open, summing samples into acc
module seg_accum_array #(
  parameter int NUM_CH   = 3,
  parameter int DATA_W   = 2,
  parameter int ACC_W    = 3,
  parameter int SATURATE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH-1:0]        in_start,
  input  logic [NUM_CH-1:0]        in_end,
  input  logic [NUM_CH*DATA_W-1:0] d,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [NUM_CH*ACC_W-1:0]  q,
  output logic [NUM_CH-1:0]        q_valid,
  input  logic [NUM_CH-1:0]        q_ready,
  output logic [NUM_CH-1:0]        q_ovf,
  output logic [NUM_CH-1:0]        err
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [0:0]       state;
    logic [ACC_W-1:0] acc;
    logic             ovf_acc;
    logic [ACC_W-1:0] q_r;
    logic             q_ovf_r;
    logic             q_valid_r;
    logic             err_r;

    logic [DATA_W-1:0] d_c;
    logic [ACC_W-1:0]  d_ext;
    logic [ACC_W:0]    sum;
    logic              sum_ovf;
    logic [ACC_W-1:0]  sum_res;
    logic              accept;

    assign d_c     = d[c*DATA_W +: DATA_W];
    assign d_ext   = ACC_W'(d_c);
    // One extra bit catches the carry out; that carry is the overflow event.
    assign sum     = {1'b0, acc} + {1'b0, d_ext};
    assign sum_ovf = sum[ACC_W];
    assign sum_res = (SATURATE != 0 && sum_ovf) ? '1 : sum[ACC_W-1:0];

    assign in_ready[c] = ~q_valid_r | q_ready[c];
    assign accept      = in_valid[c] & in_ready[c];

    always_ff @(posedge clk) begin
      if (reset) begin
        state     <= ST_IDLE;
        acc       <= '0;
        ovf_acc   <= 1'b0;
        q_r       <= '0;
        q_ovf_r   <= 1'b0;
        q_valid_r <= 1'b0;
        err_r     <= 1'b0;
      end else begin
        // A consume clears the slot; a result loaded below in the same
        // cycle overrides this and keeps q_valid high.
        if (q_ready[c]) q_valid_r <= 1'b0;

        if (accept) begin
          if (in_start[c]) begin
            // A start inside an open segment drops that segment.
            if (state == ST_ACCUM) err_r <= 1'b1;
            if (in_end[c]) begin
              state     <= ST_IDLE;
              q_r       <= d_ext;
              q_ovf_r   <= 1'b0;
              q_valid_r <= 1'b1;
            end else begin
              state   <= ST_ACCUM;
              acc     <= d_ext;
              ovf_acc <= 1'b0;
            end
          end else if (state == ST_IDLE) begin
            err_r <= 1'b1;
          end else if (in_end[c]) begin
            state     <= ST_IDLE;
            q_r       <= sum_res;
            q_ovf_r   <= ovf_acc | sum_ovf;
            q_valid_r <= 1'b1;
          end else begin
            acc     <= sum_res;
            ovf_acc <= ovf_acc | sum_ovf;
          end
        end
      end
    end

    assign q[c*ACC_W +: ACC_W] = q_r;
    assign q_ovf[c]            = q_ovf_r;
    assign q_valid[c]          = q_valid_r;
    assign err[c]              = err_r;
  end

endmodule

// File: tb/tb_seg_accum_array.sv
module tb_seg_accum_array;
  localparam int NUM_CH = 3;
  localparam int DATA_W = 2;
  localparam int ACC_W  = 3;
  localparam int MAXV   = (1 << ACC_W) - 1;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        in_valid, in_start, in_end, q_ready;
  logic [NUM_CH*DATA_W-1:0] d;
  logic [NUM_CH-1:0]        in_ready, q_valid, q_ovf, err;
  logic [NUM_CH*ACC_W-1:0]  q;
  logic [NUM_CH-1:0]        in_ready_w, q_valid_w, q_ovf_w, err_w;
  logic [NUM_CH*ACC_W-1:0]  q_w;

  int checks   = 0;
  int failures = 0;

  // Reference: each open segment is tracked as a plain integer total; the
  // reported result is derived from the true total at segment close.
  bit m_open [NUM_CH];
  int m_tot  [NUM_CH];
  bit m_err  [NUM_CH];
  bit m_qv   [NUM_CH];
  bit m_ovf  [NUM_CH];
  int m_qs   [NUM_CH];
  int m_qw   [NUM_CH];

  seg_accum_array #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ACC_W(ACC_W), .SATURATE(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_start(in_start), .in_end(in_end),
    .d(d), .in_ready(in_ready), .q(q), .q_valid(q_valid), .q_ready(q_ready),
    .q_ovf(q_ovf), .err(err));

  seg_accum_array #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ACC_W(ACC_W), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_start(in_start), .in_end(in_end),
    .d(d), .in_ready(in_ready_w), .q(q_w), .q_valid(q_valid_w), .q_ready(q_ready),
    .q_ovf(q_ovf_w), .err(err_w));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      bit acc_ok, load;
      int dv;
      dv     = int'(d[c*DATA_W +: DATA_W]);
      acc_ok = in_valid[c] && (!m_qv[c] || q_ready[c]);
      load   = 1'b0;
      if (reset) begin
        m_open[c] = 0; m_tot[c] = 0; m_err[c] = 0;
        m_qv[c] = 0; m_ovf[c] = 0; m_qs[c] = 0; m_qw[c] = 0;
      end else begin
        if (acc_ok) begin
          if (in_start[c]) begin
            if (m_open[c]) m_err[c] = 1;
            m_tot[c]  = dv;
            m_open[c] = !in_end[c];
            load      = in_end[c];
          end else if (!m_open[c]) begin
            m_err[c] = 1;
          end else begin
            m_tot[c] += dv;
            if (in_end[c]) begin
              m_open[c] = 0;
              load      = 1;
            end
          end
        end
        if (load) begin
          m_qv[c]  = 1;
          m_ovf[c] = m_tot[c] > MAXV;
          m_qs[c]  = (m_tot[c] > MAXV) ? MAXV : m_tot[c];
          m_qw[c]  = m_tot[c] % (MAXV + 1);
        end else if (q_ready[c]) begin
          m_qv[c] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [NUM_CH*ACC_W-1:0] eqs, eqw;
    logic [NUM_CH-1:0]       eqv, eovf, eerr, erdy;
    for (int c = 0; c < NUM_CH; c++) begin
      eqs[c*ACC_W +: ACC_W] = ACC_W'(m_qs[c]);
      eqw[c*ACC_W +: ACC_W] = ACC_W'(m_qw[c]);
      eqv[c]  = m_qv[c];
      eovf[c] = m_ovf[c];
      eerr[c] = m_err[c];
      erdy[c] = !m_qv[c] || q_ready[c];
    end
    chk("sat_q",        64'(q),          64'(eqs));
    chk("sat_q_valid",  64'(q_valid),    64'(eqv));
    chk("sat_q_ovf",    64'(q_ovf),      64'(eovf));
    chk("sat_err",      64'(err),        64'(eerr));
    chk("sat_in_ready", 64'(in_ready),   64'(erdy));
    chk("wrap_q",       64'(q_w),        64'(eqw));
    chk("wrap_q_valid", 64'(q_valid_w),  64'(eqv));
    chk("wrap_q_ovf",   64'(q_ovf_w),    64'(eovf));
    chk("wrap_err",     64'(err_w),      64'(eerr));
    chk("wrap_in_ready",64'(in_ready_w), 64'(erdy));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic clear_in();
    in_valid = '0; in_start = '0; in_end = '0; d = '0;
  endtask

  task automatic drive(int c, bit v, bit s, bit e, int dv);
    in_valid[c] = v;
    in_start[c] = s;
    in_end[c]   = e;
    d[c*DATA_W +: DATA_W] = dv[DATA_W-1:0];
  endtask

  initial begin
    clear_in();
    q_ready = '1;
    reset   = 1'b1;
    cycle();
    cycle();
    chk("reset_q_valid", 64'(q_valid), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(3'b111));
    reset = 1'b0;

    // channel 0: 1 + 2 + 3
    drive(0, 1, 1, 0, 1); cycle();
    drive(0, 1, 0, 0, 2); cycle();
    drive(0, 1, 0, 1, 3); cycle();
    chk("ch0_sum_q", 64'(q[2:0]), 64'(6));
    chk("ch0_sum_ovf", 64'(q_ovf[0]), 64'(0));
    chk("ch0_sum_valid", 64'(q_valid[0]), 64'(1));
    clear_in(); cycle();

    // channel 1: 3 + 3 + 3 overflows in both modes
    drive(1, 1, 1, 0, 3); cycle();
    drive(1, 1, 0, 0, 3); cycle();
    drive(1, 1, 0, 1, 3); cycle();
    chk("ch1_sat_q", 64'(q[5:3]), 64'(7));
    chk("ch1_sat_ovf", 64'(q_ovf[1]), 64'(1));
    chk("ch1_wrap_q", 64'(q_w[5:3]), 64'(1));
    chk("ch1_wrap_ovf", 64'(q_ovf_w[1]), 64'(1));
    clear_in(); cycle();

    // channel 2: held result blocks the next sample
    q_ready[2] = 1'b0;
    drive(2, 1, 1, 1, 2); cycle();
    chk("ch2_hold_q", 64'(q[8:6]), 64'(2));
    drive(2, 1, 1, 1, 1); cycle();
    chk("ch2_blocked_rdy", 64'(in_ready[2]), 64'(0));
    chk("ch2_stable_q", 64'(q[8:6]), 64'(2));
    q_ready[2] = 1'b1; cycle();
    chk("ch2_reload_q", 64'(q[8:6]), 64'(1));
    chk("ch2_reload_valid", 64'(q_valid[2]), 64'(1));
    clear_in(); cycle();

    // channel 0: stray sample, then double start
    drive(0, 1, 0, 0, 1); cycle();
    chk("ch0_err_stray", 64'(err[0]), 64'(1));
    drive(0, 1, 1, 0, 1); cycle();
    drive(0, 1, 1, 0, 2); cycle();
    drive(0, 1, 0, 1, 0); cycle();
    chk("ch0_restart_q", 64'(q[2:0]), 64'(2));
    chk("ch0_err_sticky", 64'(err[0]), 64'(1));
    clear_in(); cycle();

    // all channels single-sample, then reset mid-segment
    for (int c = 0; c < NUM_CH; c++) drive(c, 1, 1, 1, 2);
    cycle();
    chk("all_single_q", 64'(q), 64'(9'b010_010_010));
    chk("all_single_valid", 64'(q_valid), 64'(3'b111));
    for (int c = 0; c < NUM_CH; c++) drive(c, 1, 1, 0, 1);
    cycle();
    for (int c = 0; c < NUM_CH; c++) drive(c, 1, 0, 1, 1);
    reset = 1'b1; cycle();
    chk("rst_mid_q", 64'(q), 64'(0));
    chk("rst_mid_valid", 64'(q_valid), 64'(0));
    chk("rst_mid_err", 64'(err), 64'(0));
    reset = 1'b0;
    clear_in(); cycle();
    for (int c = 0; c < NUM_CH; c++) drive(c, 1, 0, 1, 3);
    cycle();
    chk("rst_no_result", 64'(q_valid), 64'(0));
    clear_in(); cycle();

    // randomized traffic against the reference
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        in_valid[c] = ($urandom_range(0, 3) != 0);
        in_start[c] = ($urandom_range(0, 3) == 0);
        in_end[c]   = ($urandom_range(0, 3) == 0);
        q_ready[c]  = ($urandom_range(0, 3) != 0);
      end
      d     = NUM_CH*DATA_W'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg_accum_array.md
SEG_ACCUM_ARRAY -- requirements
Module: seg_accum_array

Interface
REQ-001 Parameter NUM_CH, default 3, sets the number of independent channels (1..16).
REQ-002 Parameter DATA_W, default 2, sets the per-channel sample width.
REQ-003 Parameter ACC_W, default 3, sets the per-channel accumulator/result width (ACC_W >= DATA_W).
REQ-004 Parameter SATURATE, default 1, selects overflow mode: 1 = clamp to all-ones, 0 = wrap modulo 2^ACC_W.
REQ-005 One clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 in_valid  input  NUM_CH  per-channel sample valid.
REQ-009 in_start  input  NUM_CH  per-channel marker: the sample opens a segment.
REQ-010 in_end  input  NUM_CH  per-channel marker: the sample closes a segment.
REQ-011 d  input  NUM_CH*DATA_W  samples; channel c occupies bits [c*DATA_W +: DATA_W], unsigned.
REQ-012 in_ready  output  NUM_CH  per-channel accept; combinational: in_ready[c] = !q_valid[c] | q_ready[c].
REQ-013 q  output  NUM_CH*ACC_W  segment results; channel c at [c*ACC_W +: ACC_W].
REQ-014 q_valid  output  NUM_CH  per-channel result valid.
REQ-015 q_ready  input  NUM_CH  per-channel result consume.
REQ-016 q_ovf  output  NUM_CH  per-channel overflow flag, qualified by q_valid.
REQ-017 err  output  NUM_CH  per-channel sticky protocol-error flag.

Function
REQ-018 A sample is accepted on channel c when in_valid[c] and in_ready[c] are both high at a rising clk edge; unaccepted samples have no effect.
REQ-019 Each channel has an independent two-state FSM, IDLE and ACCUM; channels never interact.
REQ-020 IDLE + accepted start without end -> ACCUM; acc <= zero-extended d; ovf_acc <= 0.
REQ-021 IDLE + accepted start with end -> stays IDLE; q <= zero-extended d, q_ovf <= 0, q_valid <= 1 (single-sample segment).
REQ-022 IDLE + accepted sample without start -> ignored; err[c] <= 1.
REQ-023 ACCUM + accepted sample with neither marker -> acc <= acc + d under overflow mode; ovf_acc set if the true sum exceeds 2^ACC_W-1.
REQ-024 ACCUM + accepted end without start -> IDLE; q <= acc + d under overflow mode; q_ovf <= ovf_acc OR overflow of this add; q_valid <= 1.
REQ-025 ACCUM + accepted start (with or without end) -> err[c] <= 1; the open segment is discarded and the sample is handled as in REQ-020/REQ-021.
REQ-026 Overflow mode: SATURATE=1 holds the result at 2^ACC_W-1 once exceeded; SATURATE=0 keeps the low ACC_W bits; both modes report overflow.
REQ-027 Latency: the closing sample accepted at edge t gives q_valid high after edge t, i.e. q is visible in cycle t+1.
REQ-028 q_valid[c] clears at an edge with q_ready[c] high, unless a new result is loaded at the same edge, in which case q_valid stays 1 with the new q.
REQ-029 q and q_ovf stay stable while q_valid is high and q_ready is low.
REQ-030 err is sticky and is cleared only by reset.

Reset
REQ-031 reset high at an edge: all FSMs -> IDLE; acc, q, q_ovf, q_valid and err -> 0; reset overrides every concurrent input.
REQ-032 Reset during ACCUM abandons the open segment silently; no result and no err are produced.
REQ-033 in_ready is all-ones from the first cycle after reset.

Verification
REQ-034 Ch0: start d=1, data d=2, end d=3, q_ready=1 -> q[2:0]=6, q_ovf=0, q_valid one cycle after the end sample.
REQ-035 Ch1, SATURATE=1: start 3, data 3, end 3 -> q=7, q_ovf=1; same stimulus with SATURATE=0 -> q=1, q_ovf=1.
REQ-036 Ch2 result held with q_ready=0 -> in_ready[2]=0, q stable, a further start on ch2 not accepted; raising q_ready accepts it in the same cycle.
REQ-037 Sample with no start in IDLE, then a double start -> err set after the first; the second start restarts acc with its own d; err stays 1 until reset.
REQ-038 Start+end in one sample d=2 on all channels at once -> every channel gives q=2 next cycle; reset asserted mid-segment -> all outputs 0, no result emitted.
